fetch_pc_gen: RTL
=================

Name: fetch_pc_gen

Overview:
Two-stage fetch front end that sits directly upstream of the branch predictor and consumes its prediction.
- F1: owns the PC and drives it to the instruction memory and to the predictor query port.
- F2: receives the instruction and the 1-cycle-registered prediction for the same PC, predecodes JAL/B-type, and redirects on a predicted-taken branch.
- Output goes to decode through a valid/ready register; the execute-stage mispredict redirect overrides everything.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset (word aligned)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  reset, asynchronous, active-high
imem_addr  out  32  fetch address; synchronous memory, data valid next cycle
imem_rdata  in  32  instruction for imem_addr of previous cycle
bpu_query_addr  out  32  predictor query address, always equal to imem_addr
bpu_prediction  in  1  registered prediction for previous cycle's bpu_query_addr
redirect_valid  in  1  execute mispredict/flush
redirect_pc  in  32  corrected PC
out_valid  out  1  instruction valid to decode
out_ready  in  1  decode accepts
out_instr  out  32  instruction
out_pc  out  32  its PC
out_pred_taken  out  1  front end redirected after this instruction
out_pred_target  out  32  predicted target (0 when not taken)

Behaviour:
- State: pc_q, f2_valid, f2_pc, output register.
- Reset values: pc_q=RESET_PC, f2_valid=0, f2_pc=0, out_valid=0, out_instr/out_pc/out_pred_target=0, out_pred_taken=0.
- advance = !out_valid || out_ready.
- Address select: imem_addr = bpu_query_addr = advance ? pc_q : f2_pc.
  - This is a combinational out_ready→imem_addr path, permitted.
  - When stalled, the F2 PC is replayed, so next-cycle rdata and prediction still match f2_pc.
- Predecode on imem_rdata when f2_valid:
  - opcode 7'b1101111 (JAL): taken = 1; imm = J-immediate, sign-extended.
  - opcode 7'b1100011 (branch): taken = bpu_prediction; imm = B-immediate, sign-extended.
  - Otherwise taken = 0.
  - target = f2_pc + imm, modulo 2^32.
- Priority each cycle, highest first:
  1. redirect_valid:
     - pc_q<=redirect_pc; f2_valid<=0; out_valid<=0 (flush even if stalled).
     - F2 contents discarded; next cycle issues redirect_pc.
  2. !advance: hold pc_q, f2_*, and the output register.
  3. advance && f2_valid && taken:
     - Output register <= {imem_rdata, f2_pc, 1, target}; out_valid<=1.
     - pc_q<=target; f2_valid<=0, squashing the f2_pc+4 request issued this cycle.
     - Exactly 1 bubble.
  4. advance, otherwise:
     - If f2_valid, output register <= {imem_rdata, f2_pc, 0, 0} and out_valid<=1; else out_valid<=0.
     - f2_pc<=pc_q; f2_valid<=1; pc_q<=pc_q+4 (wraps at 2^32).
- Steady state without stalls or redirects: one instruction per cycle. First instruction reaches out_valid 2 cycles after reset release or redirect.
- redirect_valid and out_ready both high in the same cycle: redirect wins; the output is invalidated and the handshake is not counted as delivered.
- No alignment checking; low 2 PC bits pass through unchanged.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately (async).

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched (32), perf_pred_redirects (32), perf_stall_cycles (32). All reset 0 and wrap at 2^32.
  - perf_fetched increments on each out_valid&&out_ready.
  - perf_pred_redirects increments on each case-3 event.
  - perf_stall_cycles increments on each cycle with out_valid && !out_ready.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. Reset release, out_ready=1, memory of NOPs (32'h00000013) -> out_pc 0x0,0x4,0x8,... one per cycle; first out_valid 2 cycles after release; out_pred_taken=0.
2. JAL at 0x8 with imm=+0x100 -> out at pc 0x8 with pred_taken=1, target 0x108; one bubble; next out_pc=0x108; 0xC never delivered.
3. BEQ at 0x10 with imm=-0x10: prediction=1 -> next out_pc=0x0; prediction=0 -> next out_pc=0x14, pred_taken=0.
4. out_ready=0 for 3 cycles while out_valid at pc 0x20 -> outputs stable; imem_addr=0x24 replayed during the stall. After release the sequence continues 0x24, 0x28 with none lost or duplicated.
5. redirect_valid with redirect_pc=0x400 during a stall and a pending predicted JAL -> out_valid=0 next cycle; JAL target ignored; next delivered out_pc=0x400.
6. rst pulsed while out_valid=1 -> out_valid=0 immediately; fetch restarts at RESET_PC. With FETCH_PERF_EN, all counters read 0.

Source files
------------

// File: rtl/fetch_pc_gen_if.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen_if
//
// Instruction channel from the fetch front end to decode.
//
// Handshake: a transfer happens on a rising clk edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low, the
// producer holds out_instr/out_pc/out_pred_taken/out_pred_target stable. The
// producer may drop out_valid without a transfer only when the pipeline is
// flushed by a redirect or by reset. out_valid never depends on out_ready.
//
// Signals:
//   out_valid        producer -> consumer  instruction present
//   out_ready        consumer -> producer  consumer accepts this cycle
//   out_instr[31:0]  producer -> consumer  instruction word
//   out_pc[31:0]     producer -> consumer  PC of out_instr
//   out_pred_taken   producer -> consumer  front end redirected after it
//   out_pred_target  producer -> consumer  predicted target (0 if not taken)
//
// Modports: master = fetch side, slave = decode side.
// ---------------------------------------------------------------------------
interface fetch_pc_gen_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pred_taken;
  logic [31:0] out_pred_target;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pred_taken,
    output out_pred_target,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pred_taken,
    input  out_pred_target,
    output out_ready
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// ---------------------------------------------------------------------------
// fetch_pc_gen
//
// Two-stage fetch front end sitting directly upstream of the branch predictor.
//   F1 : owns pc_q and presents it to the instruction memory and to the
//        predictor query port (both see the same address).
//   F2 : receives the instruction and the registered prediction for the PC
//        issued one cycle earlier, predecodes JAL / B-type, and steers pc_q to
//        the target when the instruction is predicted taken.
//   OUT: valid/ready register toward decode.
// An execute-stage redirect overrides everything and flushes F2 and OUT.
//
// Parameters:
//   RESET_PC          first PC fetched after reset (word aligned)
//
// Ports:
//   clk               clock, all state on rising edge
//   rst               asynchronous, active-high reset
//   imem_addr         fetch address (synchronous memory, data next cycle)
//   imem_rdata        instruction for the previous cycle's imem_addr
//   bpu_query_addr    predictor query address, always equal to imem_addr
//   bpu_prediction    registered prediction for previous cycle's query
//   redirect_valid    execute mispredict / flush
//   redirect_pc       corrected PC
//   dec               decode channel (fetch_pc_gen_if.master)
//
// Optional build macro FETCH_PERF_EN adds free-running 32-bit counters:
//   perf_fetched         instructions handed to decode
//   perf_pred_redirects  front-end predicted-taken redirects
//   perf_stall_cycles    cycles with out_valid high and out_ready low
// Without the macro those ports and counters do not exist.
// ---------------------------------------------------------------------------
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       bpu_query_addr,
  input  logic              bpu_prediction,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  fetch_pc_gen_if.master    dec
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_pred_redirects,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // What the pipeline does on the coming edge, in priority order.
  typedef enum logic [1:0] {
    ACT_FLUSH = 2'd0,  // execute redirect: load redirect_pc, drop F2/OUT
    ACT_HOLD  = 2'd1,  // decode back-pressure: freeze everything
    ACT_PRED  = 2'd2,  // F2 predicted taken: emit it, steer to target
    ACT_SEQ   = 2'd3   // sequential advance
  } fetch_act_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0] pc_q;
  logic        f2_valid;
  logic [31:0] f2_pc;

  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        out_taken_q;
  logic [31:0] out_target_q;

  // -------------------------------------------------------------------------
  // Combinational
  // -------------------------------------------------------------------------
  logic        advance;
  logic [6:0]  opcode;
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic [31:0] pd_imm;
  logic        pd_taken;
  logic [31:0] pd_target;
  fetch_act_t  act;

  // The output register can take a new entry when it is empty or being
  // drained this cycle.
  assign advance = !out_valid_q || dec.out_ready;

  // When stalled, the F2 PC is re-issued so that next cycle's imem_rdata and
  // bpu_prediction still belong to f2_pc. This makes imem_addr depend
  // combinationally on out_ready.
  always_comb begin
    imem_addr      = advance ? pc_q : f2_pc;
    bpu_query_addr = imem_addr;
  end

  // Predecode of the instruction sitting in F2.
  always_comb begin
    opcode   = imem_rdata[6:0];
    j_imm    = {{12{imem_rdata[31]}}, imem_rdata[19:12], imem_rdata[20],
                imem_rdata[30:21], 1'b0};
    b_imm    = {{20{imem_rdata[31]}}, imem_rdata[7], imem_rdata[30:25],
                imem_rdata[11:8], 1'b0};
    pd_taken = 1'b0;
    pd_imm   = 32'd0;
    if (f2_valid) begin
      unique case (opcode)
        OPC_JAL: begin
          pd_taken = 1'b1;
          pd_imm   = j_imm;
        end
        OPC_BRANCH: begin
          pd_taken = bpu_prediction;
          pd_imm   = b_imm;
        end
        default: begin
          pd_taken = 1'b0;
          pd_imm   = 32'd0;
        end
      endcase
    end
    // Wraps modulo 2^32.
    pd_target = f2_pc + pd_imm;
  end

  // Action select; redirect outranks a stall so a flush is never delayed.
  always_comb begin
    act = ACT_SEQ;
    if (redirect_valid) begin
      act = ACT_FLUSH;
    end else if (!advance) begin
      act = ACT_HOLD;
    end else if (pd_taken) begin
      act = ACT_PRED;
    end else begin
      act = ACT_SEQ;
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      f2_valid     <= 1'b0;
      f2_pc        <= 32'd0;
      out_valid_q  <= 1'b0;
      out_instr_q  <= 32'd0;
      out_pc_q     <= 32'd0;
      out_taken_q  <= 1'b0;
      out_target_q <= 32'd0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          // Whatever is in F2/OUT belongs to the wrong path, including an
          // entry decode may be accepting this very cycle.
          pc_q        <= redirect_pc;
          f2_valid    <= 1'b0;
          out_valid_q <= 1'b0;
        end
        ACT_HOLD: begin
          // Everything keeps its value; imem is being fed f2_pc.
        end
        ACT_PRED: begin
          out_valid_q  <= 1'b1;
          out_instr_q  <= imem_rdata;
          out_pc_q     <= f2_pc;
          out_taken_q  <= 1'b1;
          out_target_q <= pd_target;
          // The pc_q fetch issued this cycle is the fall-through path;
          // clearing f2_valid squashes it, costing exactly one bubble.
          pc_q         <= pd_target;
          f2_valid     <= 1'b0;
        end
        ACT_SEQ: begin
          out_valid_q <= f2_valid;
          if (f2_valid) begin
            out_instr_q  <= imem_rdata;
            out_pc_q     <= f2_pc;
            out_taken_q  <= 1'b0;
            out_target_q <= 32'd0;
          end
          f2_pc    <= pc_q;
          f2_valid <= 1'b1;
          pc_q     <= pc_q + 32'd4;
        end
        default: begin
        end
      endcase
    end
  end

  assign dec.out_valid       = out_valid_q;
  assign dec.out_instr       = out_instr_q;
  assign dec.out_pc          = out_pc_q;
  assign dec.out_pred_taken  = out_taken_q;
  assign dec.out_pred_target = out_target_q;

`ifdef FETCH_PERF_EN
  // -------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched        <= 32'd0;
      perf_pred_redirects <= 32'd0;
      perf_stall_cycles   <= 32'd0;
    end else begin
      // A handshake coinciding with a redirect is flushed, not delivered.
      if (out_valid_q && dec.out_ready && !redirect_valid) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (act == ACT_PRED) begin
        perf_pred_redirects <= perf_pred_redirects + 32'd1;
      end
      if (out_valid_q && !dec.out_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
